swim_pattern_tx: RTL
====================

# swim_pattern_tx

Parametrised SWIM-line bit-pattern transmitter: the next generation of the fixed-pattern SWIM reset generator. Accepts a pattern of up to `MAX_BITS` bits with a per-transfer length over a valid/ready handshake. Serialises the pattern MSB-first at `DIV` clock cycles per bit, in push-pull or open-drain mode, and samples the line mid-bit for readback. Sits between the USB-UART command path in `top` and the `SB_IO` tristate buffer on the `swim` pin.

## Interface
Parameters:
- `DIV`, 6000: clock cycles per bit; 8 kHz at 48 MHz; must be ≥ 2.
- `MAX_BITS`, 64: pattern register width.
- `OPEN_DRAIN`, 0: 0 = drive both levels; 1 = drive low only, release for 1.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock (48 MHz domain).
- `reset` in 1: synchronous, active-high.
- `pat_data` in MAX_BITS: pattern; bit `pat_len-1` is sent first.
- `pat_len` in clog2(MAX_BITS+1): bit count; values > MAX_BITS clamp to MAX_BITS.
- `pat_valid` in 1: pattern offered.
- `pat_ready` out 1: block idle; accepts when valid&ready.
- `abort` in 1: cancel the transfer in progress.
- `swim_din` in 1: line level from `SB_IO` `D_IN_0`.
- `swim_oe` out 1: `SB_IO` `OUTPUT_ENABLE`.
- `swim_dout` out 1: `SB_IO` `D_OUT_0`.
- `rx_bits` out MAX_BITS: mid-bit samples, shifted in LSB-first order of arrival.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle pulse on normal completion.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `pat_ready=1`.
  - On valid&ready: latch data, clamp the length, clear `rx_bits`, restart the bit timer, go to SHIFT.
  - If `pat_len==0`: go to DONE directly; the line is never driven.
- SHIFT:
  - Drive bit `idx`, starting at `len-1`. `idx` decrements at each bit-period end.
  - After bit 0's period, go to DONE.
- Drive rule:
  - `OPEN_DRAIN=0`: `oe=1`, `dout=bit`.
  - `OPEN_DRAIN=1`: `oe=~bit`, `dout=0`.
- Mid-bit sample: when the bit-timer count equals `DIV/2` (count is 0-based within the bit), `rx_bits <= {rx_bits[MAX_BITS-2:0], swim_din}`.
- DONE: `done=1` and `oe=0` for one cycle, then IDLE.
- Abort:
  - In SHIFT: go to IDLE next cycle, `oe=0`, no `done`. `rx_bits` keeps its partial contents.
  - In IDLE: no effect. Abort wins over a same-cycle `pat_valid` (pattern not accepted).
- `pat_valid` while busy is ignored; the data is not latched.
- Reset mid-transfer: same as abort, and additionally clears `rx_bits`.
- Reset values: `swim_oe=0`, `swim_dout=1`, `busy=0`, `done=0`, `rx_bits=0`, state IDLE.
- `pat_ready=0` while `reset` is high.

## Timing
- Accept edge = cycle 0. Bit k (0 = first sent) occupies cycles `k*DIV+1` through `(k+1)*DIV`.
- `busy=1` from cycle 1 through the DONE cycle.
- `done` at cycle `len*DIV+1`; `pat_ready=1` from cycle `len*DIV+2`.
- `len=0`: `done` at cycle 1, `pat_ready` at cycle 2.
- The bit timer restarts on accept, so bit edges are aligned to the handshake (no free-running divider phase).
- Outputs are registered.
- Abort sampled at cycle n: `oe=0` and `pat_ready=1` at cycle n+1.

## Structure
- Sub-module `swim_bit_timer(clk, reset, restart, period_end, mid)`: down-counter of width clog2(DIV), parametrised by `DIV`.
- Shared header `swim_defs.vh` holds:
  - state encodings (IDLE/SHIFT/DONE);
  - `SWIM_DIV_48M_8K = 6000`;
  - the canonical 36-bit SWIM entry pattern `36'hFF3333557`.
- `top` instantiates `SB_IO` (PIN_TYPE 6'b1010_01) on `swim`. The block itself has no tristate logic.

## Test plan
All scenarios use DIV=4, MAX_BITS=8.
1. Reset held 3 cycles -> `oe=0`, `dout=1`, `busy=0`, `done=0`, `rx_bits=0`; `pat_ready` 0 during reset, 1 on the first cycle after.
2. Push-pull, `pat_len=4`, `pat_data=8'h0A` -> `dout` = 1,0,1,0, each held 4 cycles over cycles 1–16; `done` at cycle 17; `pat_ready` at cycle 18.
3. OPEN_DRAIN=1, loopback `din = oe ? dout : 1`, same pattern -> `oe` = 0,1,0,1 per bit; `rx_bits[3:0]=4'b1010`.
4. `pat_len=0` -> `done` at cycle 1, `oe` never asserted, `rx_bits=0`.
5. `pat_len=8`, `pat_data=8'hFF`, abort at cycle 6 -> `oe=0` and `pat_ready=1` at cycle 7, no `done`. A `pat_valid` pulse at cycle 3 is ignored.
6. `pat_len=15` (clamped to 8), `pat_data=8'h81`, reset at cycle 10 -> until cycle 10 `dout` follows 1 (cycles 1–4), then 0; outputs return to reset values at cycle 11, `rx_bits=0`.

Source files
------------

// File: rtl/swim_pattern_tx_pkg.sv
// Shared definitions for the SWIM pattern transmitter: FSM encoding and
// canonical line constants used by the command path.
package swim_pattern_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } swim_state_t;

    // 8 kHz bit rate from the 48 MHz system clock.
    localparam int SWIM_DIV_48M_8K = 6000;

    // Entry sequence the host sends to put the target into SWIM mode.
    localparam logic [35:0] SWIM_ENTRY_PATTERN = 36'hFF3333557;

endpackage

// File: rtl/swim_bit_timer.sv
// Bit-period down-counter: flags the last cycle of each bit and the mid-bit
// sample point. Restart realigns the bit grid to the accept handshake.
module swim_bit_timer #(
    parameter int DIV = 6000
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic period_end,
    output logic mid
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LOAD    = CW'(DIV - 1);
    // Elapsed count DIV/2 within the bit, seen from the down-counter.
    localparam logic [CW-1:0] MID_CNT = CW'(DIV - 1 - DIV / 2);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || restart || cnt == '0) begin
            cnt <= LOAD;
        end else begin
            cnt <= cnt - CW'(1);
        end
    end

    assign period_end = (cnt == '0);
    assign mid        = (cnt == MID_CNT);

endmodule

// File: rtl/swim_pattern_tx.sv
// SWIM-line pattern serialiser: MSB-first, DIV clocks per bit, push-pull or
// open-drain drive, mid-bit readback of the line into rx_bits.
module swim_pattern_tx
    import swim_pattern_tx_pkg::*;
#(
    parameter int DIV        = 6000,
    parameter int MAX_BITS   = 64,
    parameter int OPEN_DRAIN = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [MAX_BITS-1:0]               pat_data,
    input  logic [$clog2(MAX_BITS+1)-1:0]     pat_len,
    input  logic                              pat_valid,
    output logic                              pat_ready,
    input  logic                              abort,
    input  logic                              swim_din,
    output logic                              swim_oe,
    output logic                              swim_dout,
    output logic [MAX_BITS-1:0]               rx_bits,
    output logic                              busy,
    output logic                              done,
    output logic [1:0]                        state_dbg
);

    localparam int LW = $clog2(MAX_BITS + 1);
    localparam int IW = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

    // Handshake: a pattern is taken on any clock edge where pat_valid and
    // pat_ready are both high and abort is low; pat_ready is high only in IDLE
    // outside reset, and the offered data need not be held after that edge.

    swim_state_t         state;
    logic [MAX_BITS-1:0] data_q;
    logic [IW-1:0]       idx;
    logic [LW-1:0]       len_c;
    logic [IW-1:0]       first_idx;
    logic                accept;
    logic                bit_end;
    logic                bit_mid;

    assign pat_ready = (state == ST_IDLE) && !reset;
    assign accept    = pat_valid && pat_ready && !abort;
    assign len_c     = (pat_len > LW'(MAX_BITS)) ? LW'(MAX_BITS) : pat_len;
    assign first_idx = IW'(len_c - LW'(1));
    assign state_dbg = state;

    swim_bit_timer #(.DIV(DIV)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .restart    (accept),
        .period_end (bit_end),
        .mid        (bit_mid)
    );

    // Returns {oe, dout} for one data bit.
    function automatic logic [1:0] line_drive(input logic b);
        if (OPEN_DRAIN != 0) begin
            return {~b, 1'b0};
        end
        return {1'b1, b};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            data_q    <= '0;
            idx       <= '0;
            swim_oe   <= 1'b0;
            swim_dout <= 1'b1;
            rx_bits   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (accept) begin
                        data_q  <= pat_data;
                        rx_bits <= '0;
                        busy    <= 1'b1;
                        if (len_c == '0) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            swim_oe   <= 1'b0;
                            swim_dout <= 1'b1;
                        end else begin
                            state                <= ST_SHIFT;
                            idx                  <= first_idx;
                            {swim_oe, swim_dout} <= line_drive(pat_data[first_idx]);
                        end
                    end
                end
                ST_SHIFT: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        swim_oe   <= 1'b0;
                        swim_dout <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        if (bit_mid) begin
                            rx_bits <= {rx_bits[MAX_BITS-2:0], swim_din};
                        end
                        if (bit_end) begin
                            if (idx == '0) begin
                                state     <= ST_DONE;
                                done      <= 1'b1;
                                swim_oe   <= 1'b0;
                                swim_dout <= 1'b1;
                            end else begin
                                idx                  <= idx - IW'(1);
                                {swim_oe, swim_dout} <= line_drive(data_q[idx - IW'(1)]);
                            end
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
